// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words on a valid/ready handshake and streams them one bit per clock.
// Optional even-parity trailer bit per word when SERIALIZER_PARITY_EN is defined.
module bit_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: a word moves on a rising edge where s_valid && s_ready; s_ready depends only on state,
  // and s_valid may drop at any time without a transfer taking place.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef SERIALIZER_PARITY_EN
    , ST_PARITY = 2'd2
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic             busy_q, busy_d;
  logic             xfer;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ST_IDLE:   s_ready = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      ST_PARITY: s_ready = 1'b1;
      ST_SHIFT:  s_ready = 1'b0;
`else
      ST_SHIFT:  s_ready = (cnt_q == '0);
`endif
      default:   s_ready = 1'b0;
    endcase
  end

  assign xfer = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    word_done_d = 1'b0;
    busy_d      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          ser_out_d   = head_bit(shreg_q);
          shreg_d     = advance(shreg_q);
          cnt_d       = cnt_q - CW'(1);
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
`ifndef SERIALIZER_PARITY_EN
          word_done_d = (cnt_q == CW'(1));
`endif
        end else begin
`ifdef SERIALIZER_PARITY_EN
          state_d     = ST_PARITY;
          ser_out_d   = parity_q;
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
          word_done_d = 1'b1;
`else
          state_d     = ST_IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PARITY: state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase

    // A transfer only happens in IDLE or a last-bit cycle, so it overrides whatever the case chose.
    if (xfer) begin
      state_d     = ST_SHIFT;
      cnt_d       = CW'(WIDTH - 1);
      ser_out_d   = head_bit(s_data);
      shreg_d     = advance(s_data);
      ser_valid_d = 1'b1;
      busy_d      = 1'b1;
      word_done_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_d    = ^s_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
      busy_q      <= busy_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Bench for bit_stream_serializer: an MSB-first and an LSB-first instance share stimulus and are
// compared every cycle against a queue-based line model; honours SERIALIZER_PARITY_EN.
module tb_bit_stream_serializer;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         m_ready, m_out, m_valid, m_done, m_busy;
  logic         l_ready, l_out, l_valid, l_done, l_busy;

  // Entries are {last, bit} for line cycles still to come; cur_* is {valid, last, bit} on the line now.
  logic [1:0]   exp_msb_q[$];
  logic [1:0]   exp_lsb_q[$];
  logic [2:0]   cur_m, cur_l;
  logic [31:0]  rec_m, rec_l;
  bit           last_xfer;
  int           n_cmp, n_bad;

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(m_ready),
    .ser_out(m_out), .ser_valid(m_valid), .word_done(m_done), .busy(m_busy)
  );

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(l_ready),
    .ser_out(l_out), .ser_valid(l_valid), .word_done(l_done), .busy(l_busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line image of one word given in transmit order: data bits, then the parity bit when enabled.
  function automatic logic [31:0] line_bits(input logic [W-1:0] seq);
`ifdef SERIALIZER_PARITY_EN
    return {23'd0, seq, ^seq};
`else
    return {24'd0, seq};
`endif
  endfunction

  function automatic int line_len();
`ifdef SERIALIZER_PARITY_EN
    return W + 1;
`else
    return W;
`endif
  endfunction

  task automatic push_word(input logic [W-1:0] d);
    bit par_en;
`ifdef SERIALIZER_PARITY_EN
    par_en = 1'b1;
`else
    par_en = 1'b0;
`endif
    for (int i = 0; i < W; i++) begin
      exp_msb_q.push_back({(i == W - 1) && !par_en, d[W-1-i]});
      exp_lsb_q.push_back({(i == W - 1) && !par_en, d[i]});
    end
    if (par_en) begin
      exp_msb_q.push_back({1'b1, ^d});
      exp_lsb_q.push_back({1'b1, ^d});
    end
  endtask

  task automatic clear_model();
    exp_msb_q.delete();
    exp_lsb_q.delete();
    cur_m = 3'b000;
    cur_l = 3'b000;
  endtask

  task automatic compare_all(input string phase);
    check({phase, ":m_out"},   m_out,   cur_m[0]);
    check({phase, ":m_valid"}, m_valid, cur_m[2]);
    check({phase, ":m_done"},  m_done,  cur_m[1]);
    check({phase, ":m_busy"},  m_busy,  cur_m[2]);
    check({phase, ":m_ready"}, m_ready, exp_msb_q.size() == 0);
    check({phase, ":l_out"},   l_out,   cur_l[0]);
    check({phase, ":l_valid"}, l_valid, cur_l[2]);
    check({phase, ":l_done"},  l_done,  cur_l[1]);
    check({phase, ":l_busy"},  l_busy,  cur_l[2]);
    check({phase, ":l_ready"}, l_ready, exp_lsb_q.size() == 0);
  endtask

  // One clock: the model takes a word only when nothing is left to send after the current line cycle.
  task automatic cycle(input string phase);
    bit xfer;
    xfer = s_valid && !rst && (exp_msb_q.size() == 0);
    @(posedge clk);
    if (rst) begin
      clear_model();
      last_xfer = 1'b0;
    end else begin
      if (xfer) push_word(s_data);
      last_xfer = xfer;
      cur_m = (exp_msb_q.size() != 0) ? {1'b1, exp_msb_q.pop_front()} : 3'b000;
      cur_l = (exp_lsb_q.size() != 0) ? {1'b1, exp_lsb_q.pop_front()} : 3'b000;
    end
    @(negedge clk);
    compare_all(phase);
    if (m_valid) rec_m = {rec_m[30:0], m_out};
    if (l_valid) rec_l = {rec_l[30:0], l_out};
  endtask

  // driver tasks
  task automatic send_word(input logic [W-1:0] d, input string phase);
    bit ok;
    ok      = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      cycle(phase);
      ok = last_xfer;
    end
    check({phase, ":xfer_timeout"}, ok, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n, input string phase);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_data = W'($urandom);
      cycle(phase);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    rec_m   = '0;
    rec_l   = '0;
    clear_model();
    last_xfer = 1'b0;

    // Reset held with a word offered: nothing is taken, outputs stay clear.
    #2 rst = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    for (int i = 0; i < 3; i++) cycle("reset");
    rst = 1'b0;
    idle(2, "post_reset");

    // Single word.
    rec_m = '0; rec_l = '0;
    send_word(8'hB0, "single");
    idle(W + 3, "single_tail");
    check("single_line_m", rec_m, line_bits(8'hB0));
    check("single_line_l", rec_l, line_bits(8'h0D));

    // Back-to-back words with s_valid held.
    rec_m = '0; rec_l = '0;
    send_word(8'hB5, "b2b");
    send_word(8'h0F, "b2b");
    idle(2 * W + 4, "b2b_tail");
    check("b2b_line_m", rec_m, (line_bits(8'hB5) << line_len()) | line_bits(8'h0F));
    check("b2b_line_l", rec_l, (line_bits(8'hAD) << line_len()) | line_bits(8'hF0));

    // LSB-first pattern.
    rec_m = '0; rec_l = '0;
    send_word(8'h0D, "lsb");
    idle(W + 3, "lsb_tail");
    check("lsb_line_l", rec_l, line_bits(8'hB0));
    check("lsb_line_m", rec_m, line_bits(8'h0D));

    // Asynchronous reset after three bits of a word.
    send_word(8'hFF, "mid_rst");
    cycle("mid_rst");
    cycle("mid_rst");
    #2 rst = 1'b1;
    #1;
    clear_model();
    compare_all("async_rst");
    s_valid = 1'b1;
    s_data  = 8'h3C;
    cycle("rst_held");
    rst = 1'b0;
    s_valid = 1'b0;
    rec_m = '0; rec_l = '0;
    send_word(8'h80, "after_rst");
    idle(W + 3, "after_rst_tail");
    check("after_rst_line_m", rec_m, line_bits(8'h80));
    check("after_rst_line_l", rec_l, line_bits(8'h01));

    // Randomized traffic with bursty valid.
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = W'($urandom);
      cycle("random");
    end
    idle(W + 4, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_stream_serializer.md
# bit_stream_serializer

Upstream feeder for the serial pattern-detector stage. It accepts parallel words over a valid/ready handshake and emits them one bit per clock on a serial line with a qualifying valid strobe. The detector consumes `ser_out` as its `in` input, gated by `ser_valid`. Back-to-back words stream with no idle gap, so multi-bit patterns spanning word boundaries are presented contiguously.

## Interface
- `WIDTH`, default 8: bits per parallel word; legal range 2..64.
- `MSB_FIRST`, default 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_data`  in  WIDTH  parallel word; sampled only on handshake.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  serializer can accept a word this cycle.
- `ser_out`  out  1  serial data bit.
- `ser_valid`  out  1  `ser_out` carries a valid stream bit this cycle.
- `word_done`  out  1  one-cycle pulse coincident with the final serial bit of a word.
- `busy`  out  1  a word is currently being shifted out.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro defined).
- Handshake: a transfer occurs on a rising edge where `s_valid && s_ready`. `s_data` is captured into the shift register, and the bit counter loads WIDTH-1.
- `s_ready` is combinational from state. It is 1 in IDLE, and 1 in the cycle carrying the last bit of the current word (SHIFT with count 0, or PARITY when enabled). It is 0 otherwise.
- IDLE: on transfer, go to SHIFT; else stay in IDLE.
- SHIFT: each cycle presents one bit, then shifts the register and decrements the count.
  - Count 0 without parity: on transfer, reload and stay in SHIFT; else go to IDLE.
  - Count 0 with parity: go to PARITY.
- PARITY: on transfer, reload and go to SHIFT; else go to IDLE.
- Bit order: MSB_FIRST=1 sends s_data[WIDTH-1] down to s_data[0]. MSB_FIRST=0 sends s_data[0] up to s_data[WIDTH-1].
- `ser_out`, `ser_valid`, `word_done` and `busy` are registered outputs.
  - `ser_valid` = 1 and `busy` = 1 for every cycle a data or parity bit is presented.
  - In IDLE, `ser_out` = 0 and `ser_valid` = 0.
- `s_valid` may deassert at any time without a transfer. No data is lost, and the word is not captured.
- Counter width is $clog2(WIDTH). Counter decrement never wraps below 0, because the last-bit state always reloads or exits.

## Timing
- Reset value of all outputs, held while `rst` is high:
  - `ser_out` = 0, `ser_valid` = 0, `word_done` = 0, `busy` = 0.
  - State = IDLE, so `s_ready` = 1. No handshake is taken while `rst` is high.
- Latency: transfer at edge k puts the first bit on `ser_out` in the cycle after edge k. The last data bit appears in the cycle after edge k+WIDTH-1.
- Word length on the line: WIDTH cycles, or WIDTH+1 with parity.
- Back-to-back: a transfer in the last-bit cycle puts the next word's first bit in the immediately following cycle. `ser_valid` stays continuously 1.
- `word_done` is high for exactly one cycle per word, aligned with the final bit: the last data bit, or the parity bit when enabled.
- Reset mid-word: outputs clear asynchronously and the partial word is discarded. After `rst` falls, the next word starts cleanly from its first bit.

## Configuration
- `SERIALIZER_PARITY_EN` defined:
  - After the last data bit, one PARITY cycle presents even parity (XOR of the captured word) with `ser_valid` = 1.
  - `word_done` and `s_ready` move to that cycle.
- Not defined: the PARITY state and its logic are absent. Words are exactly WIDTH bits, and `word_done` / `s_ready` align with the last data bit.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately, `s_ready` = 1, no transfer while `rst` is high.
- Single word, WIDTH=8, MSB_FIRST=1, s_data=8'hB0 -> `ser_out` = 1,0,1,1,0,0,0,0 over 8 cycles with `ser_valid` = 1, `word_done` only on the 8th bit, then IDLE.
- Back-to-back: 8'hB5 then 8'h0F, `s_valid` held -> 16 contiguous valid bits 1,0,1,1,0,1,0,1,0,0,0,0,1,1,1,1. `s_ready` = 1 only in IDLE and in bit cycles 8 and 16.
- LSB-first: MSB_FIRST=0, s_data=8'h0D -> `ser_out` = 1,0,1,1,0,0,0,0.
- Reset mid-word: 8'hFF, `rst` pulsed after 3 bits -> `ser_valid` drops at once. A following word 8'h80 emits exactly 1,0,0,0,0,0,0,0.
- With `SERIALIZER_PARITY_EN`: 8'hB0 -> 8 data bits, then a 9th bit = 1, with `word_done` and `s_ready` on the 9th cycle.
